reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on reset sequencer that releases N downstream reset domains in a fixed order, each after a programmable dwell time. Once every domain is released, it raises a final `seq_done` enable. It sits at the top of the design between the board reset and the memory, processing-element, pooling and display blocks. It generalises the fixed five-state controller with:

- an arbitrary stage count,
- per-stage dwell times,
- a synchronous soft-restart,
- a readable stage index,
- an optional ready-driven early advance with timeout reporting.

## Interface
- `N_STAGES`, default 4: number of sequenced reset outputs; minimum 1.
- `CNT_W`, default 32: dwell counter width.
- `HOLD_CYCLES`, default 2001: cycles all resets are held after reset release; 0 is treated as 1.
- `STAGE_CYCLES`, default {32'd20001, 32'd20001, 32'd40001, 32'd2001}:
  - packed `N_STAGES*CNT_W` bits; field k is `[k*CNT_W +: CNT_W]`, with stage 0 in the LSBs.
  - Field k (T_k) is the dwell after stage k is released; 0 is treated as 1.
- `IDX_W`, derived as `$clog2(N_STAGES+1)`; not overridable.
- `clk` input, 1 bit: clock; all logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `restart` input, 1 bit: synchronous soft-restart request, sampled each edge.
- `ready` input, `N_STAGES` bits: per-stage early-advance request. Present only with `RSTSEQ_READY_EN`.
- `stage_rst` output, `N_STAGES` bits: active-high reset to domain k; 1 = domain held in reset.
- `seq_done` output, 1 bit: high once every stage is released and the last dwell has expired.
- `cur_stage` output, `IDX_W` bits: number of stages currently released (0..`N_STAGES`).
- `timeout` output, 1 bit: sticky flag for a timer-forced advance. Present only with `RSTSEQ_READY_EN`.

## Operation
- **Reset values.** While `rst`=0:
  - `stage_rst` = all ones, `seq_done` = 0, `cur_stage` = 0, `timeout` = 0.
  - FSM = HOLD, counter = 0.
- **FSM states.**
  - HOLD: all stages in reset.
  - RUN: stages 0..`cur_stage`-1 released, dwelling on stage `cur_stage`-1.
  - DONE: all stages released, `seq_done`=1.
- **Counter.** Counts 0..L-1 within the current state, then clears on advance. L is `HOLD_CYCLES` in HOLD, or T_{`cur_stage`-1} in RUN.
- **HOLD → RUN** on the edge where the counter equals `HOLD_CYCLES`-1. On that edge: `stage_rst[0]` ← 0 and `cur_stage` ← 1.
- **RUN, stage k+1 released** (`cur_stage` = k+1 < `N_STAGES`) on the edge where the counter equals T_k-1. On that edge: `stage_rst[k+1]` ← 0 and `cur_stage` increments.
- **RUN → DONE** when `cur_stage`=`N_STAGES` and the counter equals T_{N-1}-1. On that edge: `seq_done` ← 1.
- **DONE** is absorbing: the counter is frozen and outputs are stable until `restart` or `rst`.
- **Release order.** Released stages are never re-asserted except by `restart` or `rst`. `stage_rst` is always a thermometer code: bits ≥ `cur_stage` are 1, bits < `cur_stage` are 0.
- **Restart.** `restart`=1 in any state, on the next edge:
  - FSM ← HOLD, counter ← 0, `stage_rst` ← all ones, `seq_done` ← 0, `cur_stage` ← 0.
  - `timeout` is cleared.
  - Restart has priority over any simultaneous advance.
  - Restart held high keeps the block in HOLD with the counter at 0.
- **Reset mid-sequence.** An asynchronous `rst` assertion immediately returns every output to its reset value; no edge is required.
- **Width rule.** A field ≥ 2^CNT_W cannot occur (fields are `CNT_W` bits). The counter comparison uses unsigned `CNT_W`-bit arithmetic.

## Timing
- All outputs come directly from flops. There is no combinational path from `restart` or `ready` to any output.
- Let edge 1 be the first rising edge after `rst` deasserts (reset recovery met). Let H = max(`HOLD_CYCLES`,1) and T_k = max(field k,1).
  - `stage_rst[0]` falls after edge H.
  - `stage_rst[k]` falls after edge H+T_0+…+T_{k-1}.
  - `seq_done` rises after edge H+ΣT_k.
- Restart latency: 1 edge. After restart sampled at edge R, `stage_rst[0]` falls after edge R+H.

## Configuration
- **`RSTSEQ_READY_EN` undefined.** Purely timed advance as above; `ready` and `timeout` ports are absent.
- **`RSTSEQ_READY_EN` defined.**
  - In RUN on stage k, the block advances on the first edge where `ready[k]`=1 is sampled, or where the counter equals T_k-1, whichever comes first. T_k therefore acts as a timeout.
  - If the advance is forced by the counter while `ready[k]`=0, `timeout` ← 1. It is sticky until `restart` or `rst`.
  - `ready` is ignored in HOLD and DONE.
  - `ready` bits for already-passed stages are ignored.

## Test plan
Parameters for all scenarios: `N_STAGES`=3, `CNT_W`=8, `HOLD_CYCLES`=4, fields {3,0,2}, giving T0=2, T1=1, T2=3.

1. **Basic timed sequence.** Release `rst`, then run 12 edges.
   - `stage_rst` goes 111→110 after edge 4, →100 after edge 6, →000 after edge 7.
   - `seq_done`=1 after edge 10.
   - `cur_stage` steps 0,1,2,3.
2. **Async reset mid-run.** Assert `rst` low between edges 6 and 7.
   - `stage_rst`=111, `seq_done`=0, `cur_stage`=0 immediately.
   - After re-release, the sequence repeats scenario 1 timing exactly.
3. **Restart pulse in RUN.** One-cycle `restart` at edge 5.
   - After edge 5: `stage_rst`=111 and `cur_stage`=0.
   - `stage_rst[0]` falls after edge 9; `seq_done` after edge 15.
4. **Restart coinciding with advance, and restart from DONE.**
   - `restart` at edge 4: no release, HOLD restarts.
   - `restart` after `seq_done`=1: `seq_done`=0 next edge.
5. **Early advance (`RSTSEQ_READY_EN`).** `ready[0]`=1 at edge 5; `ready[2]` held 0.
   - `stage_rst[1]` falls after edge 5.
   - Stage 2 dwell expires by timer: `timeout`=1 together with `seq_done`.
   - `restart` clears `timeout`.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Power-on reset sequencer. After the board reset is released, all downstream
// domains are held for HOLD_CYCLES. The domains are then released one by one
// in index order. Each release is followed by a programmable dwell. When the
// last dwell expires, seq_done is raised and the block stays there until a
// restart or a board reset.
//
// Optional feature: define RSTSEQ_READY_EN to add a per-stage ready input.
// With it, a stage's dwell can end early, and the dwell time acts as a
// timeout. The sticky timeout flag reports any dwell that ended on the timer.
//
// Parameters
//   N_STAGES     number of sequenced reset outputs (>= 1)
//   CNT_W        dwell counter width
//   HOLD_CYCLES  initial hold of all resets (0 behaves as 1)
//   STAGE_CYCLES packed dwell table; field k = [k*CNT_W +: CNT_W], 0 behaves as 1
//   IDX_W        derived width of cur_stage
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   restart    synchronous soft restart; level-sampled every edge
//   ready      (RSTSEQ_READY_EN) per-stage early-advance request; level-sampled
//   stage_rst  active-high reset per domain; always a thermometer code
//   seq_done   high once every stage is released and the last dwell expired
//   cur_stage  number of stages currently released (0..N_STAGES)
//   timeout    (RSTSEQ_READY_EN) sticky: a dwell ended on the timer, not on ready
//   dbg_state  current FSM state (0 = HOLD, 1 = RUN, 2 = DONE)
//
// Handshake note: restart and ready are plain level requests with no
// acknowledge. The block acts on whatever value it samples at each rising
// edge, and no input has a combinational path to any output.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned                N_STAGES     = 4,
  parameter int unsigned                CNT_W        = 32,
  parameter int unsigned                HOLD_CYCLES  = 2001,
  parameter logic [N_STAGES*CNT_W-1:0]  STAGE_CYCLES = {32'd20001, 32'd20001, 32'd40001, 32'd2001},
  localparam int unsigned               IDX_W        = $clog2(N_STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
`ifdef RSTSEQ_READY_EN
  input  logic [N_STAGES-1:0]  ready,
`endif
  output logic [N_STAGES-1:0]  stage_rst,
  output logic                 seq_done,
  output logic [IDX_W-1:0]     cur_stage,
`ifdef RSTSEQ_READY_EN
  output logic                 timeout,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Effective hold length: a programmed 0 behaves as 1.
  localparam logic [CNT_W-1:0] HOLD_RAW = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM = (HOLD_RAW == '0) ? CNT_W'(1) : HOLD_RAW;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [N_STAGES-1:0]   srst_q, srst_d;
  logic                  done_q, done_d;
`ifdef RSTSEQ_READY_EN
  logic                  to_q, to_d;
  logic                  ready_sel;
`endif

  logic [CNT_W-1:0]      t_lim [N_STAGES];
  logic [CNT_W-1:0]      dwell_lim;
  logic                  cnt_end;
  logic                  early;

  // Effective dwell per stage: a programmed 0 behaves as 1.
  for (genvar gk = 0; gk < N_STAGES; gk++) begin : g_lim
    assign t_lim[gk] = (STAGE_CYCLES[gk*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                                : STAGE_CYCLES[gk*CNT_W +: CNT_W];
  end

  // Thermometer code: bits at or above n stay in reset.
  function automatic logic [N_STAGES-1:0] therm(input logic [IDX_W-1:0] n);
    logic [N_STAGES-1:0] res;
    res = '0;
    for (int k = 0; k < int'(N_STAGES); k++) begin
      res[k] = (IDX_W'(k) >= n);
    end
    return res;
  endfunction

  // Select the dwell limit for the current state. With cur_stage == 0 the
  // hold limit applies. With cur_stage == k+1 the dwell of stage k applies.
  // In DONE the counter is frozen, so the value selected there is unused.
  always_comb begin
    dwell_lim = HOLD_LIM;
`ifdef RSTSEQ_READY_EN
    ready_sel = 1'b0;
`endif
    for (int k = 0; k < int'(N_STAGES); k++) begin
      if (cur_q == IDX_W'(k + 1)) begin
        dwell_lim = t_lim[k];
`ifdef RSTSEQ_READY_EN
        ready_sel = ready[k];
`endif
      end
    end
  end

  assign cnt_end = (cnt_q == (dwell_lim - CNT_W'(1)));

`ifdef RSTSEQ_READY_EN
  // ready for an already-passed stage is never selected, so it has no effect.
  assign early = (state_q == S_RUN) && ready_sel;
`else
  assign early = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    srst_d  = srst_q;
    done_d  = done_q;
`ifdef RSTSEQ_READY_EN
    to_d    = to_q;
`endif
    if (restart) begin
      // Restart overrides any advance that would happen on the same edge.
      state_d = S_HOLD;
      cnt_d   = '0;
      cur_d   = '0;
      srst_d  = '1;
      done_d  = 1'b0;
`ifdef RSTSEQ_READY_EN
      to_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_end) begin
            state_d = S_RUN;
            cnt_d   = '0;
            cur_d   = IDX_W'(1);
            srst_d  = therm(IDX_W'(1));
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (cnt_end || early) begin
            cnt_d = '0;
`ifdef RSTSEQ_READY_EN
            // The timer forced this advance because ready was still low.
            if (!early) begin
              to_d = 1'b1;
            end
`endif
            if (cur_q == IDX_W'(N_STAGES)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              cur_d  = cur_q + IDX_W'(1);
              srst_d = therm(cur_q + IDX_W'(1));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // Absorbing: the counter and all outputs hold their values.
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          cur_d   = '0;
          srst_d  = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      cur_q   <= '0;
      srst_q  <= '1;
      done_q  <= 1'b0;
`ifdef RSTSEQ_READY_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      srst_q  <= srst_d;
      done_q  <= done_d;
`ifdef RSTSEQ_READY_EN
      to_q    <= to_d;
`endif
    end
  end

  // Every output is driven directly by a flop.
  assign stage_rst = srst_q;
  assign seq_done  = done_q;
  assign cur_stage = cur_q;
  assign dbg_state = state_q;
`ifdef RSTSEQ_READY_EN
  assign timeout   = to_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Configuration: N_STAGES=3, CNT_W=8, HOLD_CYCLES=4, fields {3,0,2}, so the
// effective dwells are T0=2, T1=1, T2=3.
//
// The bench has three parts:
//   - Hand-written vector tables for the timed scenarios (basic sequence,
//     asynchronous reset mid-run, restart in RUN, restart coinciding with
//     release, and restart from DONE).
//   - A hand sequence for early advance, included when RSTSEQ_READY_EN is
//     defined.
//   - A randomized run of restarts and asynchronous resets, checked against a
//     reference model. The model counts edges since the last (re)start and
//     compares that count with the cumulative release times.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int HOLD = 4;
  localparam logic [N*CW-1:0] FIELDS = {8'd3, 8'd0, 8'd2};

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       restart = 1'b0;
  logic [2:0] stage_rst;
  logic       seq_done;
  logic [1:0] cur_stage;
  logic [1:0] dbg_state;
`ifdef RSTSEQ_READY_EN
  logic [2:0] ready = 3'b000;
  logic       timeout;
`endif

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_STAGES    (N),
    .CNT_W       (CW),
    .HOLD_CYCLES (HOLD),
    .STAGE_CYCLES(FIELDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
`ifdef RSTSEQ_READY_EN
    .ready     (ready),
`endif
    .stage_rst (stage_rst),
    .seq_done  (seq_done),
    .cur_stage (cur_stage),
`ifdef RSTSEQ_READY_EN
    .timeout   (timeout),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];   // {stage_rst, cur_stage, seq_done}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] r, input logic [1:0] c, input logic d);
    check({tag, "_stage_rst"}, 32'(stage_rst), 32'(r));
    check({tag, "_cur_stage"}, 32'(cur_stage), 32'(c));
    check({tag, "_seq_done"},  32'(seq_done),  32'(d));
  endtask

  // ---------------- reference model ----------------
  // rel[k] is the number of edges after which stage k is released.
  // done_at is the number of edges after which seq_done rises.
  int rel[N];
  int done_at;
  int model_e;

  task automatic model_init();
    logic [N*CW-1:0] f;
    int t;
    int h;
    f = FIELDS;
    h = (HOLD == 0) ? 1 : HOLD;
    rel[0] = h;
    for (int k = 0; k < N; k++) begin
      t = int'(f[k*CW +: CW]);
      if (t == 0) t = 1;
      if (k + 1 < N) rel[k+1] = rel[k] + t;
      else           done_at  = rel[k] + t;
    end
  endtask

  function automatic logic [5:0] model_out(input int ev);
    int c;
    logic [2:0] r;
    c = 0;
    for (int k = 0; k < N; k++) if (ev >= rel[k]) c++;
    for (int k = 0; k < N; k++) r[k] = (k >= c);
    return {r, c[1:0], (ev >= done_at)};
  endfunction

  // ---------------- vector tables ----------------
  typedef struct {
    logic       rs;
    logic [2:0] r;
    logic [1:0] c;
    logic       d;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic rs, input logic [2:0] r, input logic [1:0] c, input logic d);
    vec_t v;
    v.rs = rs; v.r = r; v.c = c; v.d = d;
    tab.push_back(v);
  endtask

  task automatic run_table(input string name, input int rows);
    for (int i = 0; i < rows; i++) begin
      restart = tab[i].rs;
      @(posedge clk);
      #1;
      check_outs($sformatf("%s_e%0d", name, i + 1), tab[i].r, tab[i].c, tab[i].d);
    end
    restart = 1'b0;
  endtask

  // Assert the reset, check the asynchronous response, then release the reset
  // at a falling edge so that the next rising edge is edge 1.
  task automatic apply_reset(input string name);
    rst = 1'b0;
    #1;
    check_outs({name, "_async"}, 3'b111, 2'd0, 1'b0);
`ifdef RSTSEQ_READY_EN
    check({name, "_timeout"}, 32'(timeout), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    model_e = 0;
  endtask

  task automatic fill_basic();
    tab.delete();
    add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);
    add(0, 3'b110, 2'd1, 0); add(0, 3'b110, 2'd1, 0); add(0, 3'b100, 2'd2, 0);
    add(0, 3'b000, 2'd3, 0); add(0, 3'b000, 2'd3, 0); add(0, 3'b000, 2'd3, 0);
    add(0, 3'b000, 2'd3, 1); add(0, 3'b000, 2'd3, 1); add(0, 3'b000, 2'd3, 1);
    add(1, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);   // restart from DONE
  endtask

`ifdef RSTSEQ_READY_EN
  task automatic step_to(input string name, input logic rs, input logic [2:0] r,
                         input logic [1:0] c, input logic d, input logic to);
    restart = rs;
    @(posedge clk);
    #1;
    check_outs(name, r, c, d);
    check({name, "_timeout"}, 32'(timeout), 32'(to));
    restart = 1'b0;
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    logic [5:0] want;
    int rs_left;
    model_init();

    // Scenario 1 (and restart from DONE): basic timed sequence.
    #1;
    apply_reset("por");
    fill_basic();
    run_table("basic", 14);

    // Scenario 2: asynchronous reset between edges 6 and 7, then a full replay.
    apply_reset("s2_pre");
    run_table("s2_first", 6);
    #3;
    rst = 1'b0;
    #1;
    check_outs("s2_midrun_async", 3'b111, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run_table("s2_replay", 12);

    // Scenario 3: one-cycle restart at edge 5.
    apply_reset("s3");
    tab.delete();
    add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);
    add(0, 3'b110, 2'd1, 0); add(1, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);
    add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0); add(0, 3'b110, 2'd1, 0);
    add(0, 3'b110, 2'd1, 0); add(0, 3'b100, 2'd2, 0); add(0, 3'b000, 2'd3, 0);
    add(0, 3'b000, 2'd3, 0); add(0, 3'b000, 2'd3, 0); add(0, 3'b000, 2'd3, 1);
    run_table("s3_restart_run", 15);

    // Scenario 4a: restart on the edge that would release stage 0.
    apply_reset("s4");
    tab.delete();
    add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);
    add(1, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0); add(0, 3'b111, 2'd0, 0);
    add(0, 3'b111, 2'd0, 0); add(0, 3'b110, 2'd1, 0);
    run_table("s4_restart_adv", 8);

`ifdef RSTSEQ_READY_EN
    // Scenario 5: early advance on ready[0] at edge 5. ready[1] is held high
    // so that stage 1 advances on ready. ready[2] is held low, so stage 2
    // ends on the timer.
    apply_reset("s5");
    ready = 3'b010;
    step_to("s5_e1", 0, 3'b111, 2'd0, 0, 0);
    step_to("s5_e2", 0, 3'b111, 2'd0, 0, 0);
    step_to("s5_e3", 0, 3'b111, 2'd0, 0, 0);
    step_to("s5_e4", 0, 3'b110, 2'd1, 0, 0);
    ready = 3'b011;
    step_to("s5_e5_early", 0, 3'b100, 2'd2, 0, 0);
    step_to("s5_e6", 0, 3'b000, 2'd3, 0, 0);
    step_to("s5_e7", 0, 3'b000, 2'd3, 0, 0);
    step_to("s5_e8", 0, 3'b000, 2'd3, 0, 0);
    step_to("s5_e9_timeout", 0, 3'b000, 2'd3, 1, 1);
    step_to("s5_e10_sticky", 0, 3'b000, 2'd3, 1, 1);
    step_to("s5_restart_clr", 1, 3'b111, 2'd0, 0, 0);
    ready = 3'b000;
`endif

    // Randomized restarts and asynchronous resets against the reference model.
    apply_reset("rnd");
    rs_left = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        #1;
        check_outs($sformatf("rnd_async_c%0d", cyc), 3'b111, 2'd0, 1'b0);
        #1;
        rst = 1'b1;
        model_e = 0;
      end
      if (rs_left == 0 && $urandom_range(0, 11) == 0) rs_left = $urandom_range(1, 3);
      restart = (rs_left != 0);
      if (rs_left != 0) rs_left--;
      @(posedge clk);
      #1;
      if (restart) model_e = 0;
      else if (model_e < 1000) model_e++;
      exp_q.push_back(model_out(model_e));
      want = exp_q.pop_front();
      check_outs($sformatf("rnd_c%0d", cyc), want[5:3], want[2:1], want[0]);
`ifdef RSTSEQ_READY_EN
      check($sformatf("rnd_c%0d_timeout", cyc), 32'(timeout), 32'(model_e >= rel[1]));
`endif
    end
    restart = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
